fu_issue: RTL and testbench

- Operand-fetch / writeback stage wrapped around the registered functional unit (fu).
- Holds an 8-entry register file and accepts register-addressed instructions over a valid/ready handshake.
- Drives the fu operand and op inputs, captures the fu result and flags one cycle later, and writes the result back, with a bypass so back-to-back dependent instructions issue every cycle.
- Exposes a host port for register initialisation and observation.

---
 rtl/fu_issue_if.sv | 25 ++
 rtl/fu_issue.sv | 108 ++++++++++
 tb/tb_fu_issue.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fu_issue_if.sv
// Instruction issue channel: a valid/ready handshake carrying a
// register-addressed op (destination plus two sources).
interface fu_issue_if #(
  parameter int OPSIZE = 5,
  parameter int AW     = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [OPSIZE-1:0] in_op;
  logic [AW-1:0]     in_rd;
  logic [AW-1:0]     in_ra;
  logic [AW-1:0]     in_rb;

  // Instruction source.
  modport master (
    output in_valid, in_op, in_rd, in_ra, in_rb,
    input  in_ready
  );

  // Issue stage.
  modport slave (
    input  in_valid, in_op, in_rd, in_ra, in_rb,
    output in_ready
  );
endinterface

// File: rtl/fu_issue.sv
// Operand-fetch / writeback stage around a registered functional unit.
// Reads operands from an 8-entry register file (with a bypass from the fu
// result), drives the fu for one cycle, and writes its result back the
// following cycle. A host port loads and observes the register file.
module fu_issue #(
  parameter int OPSIZE = 5,
  parameter int DSIZE  = 16,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  fu_issue_if.slave         in_if,
  input  logic              host_we,
  output logic              host_ready,
  input  logic [AW-1:0]     host_waddr,
  input  logic [DSIZE-1:0]  host_wdata,
  input  logic [AW-1:0]     host_raddr,
  output logic [DSIZE-1:0]  host_rdata,
  output logic [OPSIZE-1:0] fu_op_o,
  output logic [DSIZE-1:0]  fu_a_o,
  output logic [DSIZE-1:0]  fu_b_o,
  input  logic [DSIZE-1:0]  fu_f_i,
  input  logic              fu_n_i,
  input  logic              fu_c_i,
  input  logic              fu_v_i,
  input  logic              fu_z_i,
  output logic              wb_valid_o,
  output logic [AW-1:0]     wb_addr_o,
  output logic [DSIZE-1:0]  wb_data_o,
  output logic [3:0]        flags_o,
  output logic              busy_o
);

  localparam int DEPTH = 1 << AW;

  logic [DSIZE-1:0] regfile [DEPTH];
  logic             pend;
  logic [AW-1:0]    pend_rd;

  logic             issue;
  logic             host_accept;
  logic             byp_a;
  logic             byp_b;

  // Handshakes: host writes win over instructions; host writes wait out
  // any pending writeback so the two never collide on the register file.
  assign in_if.in_ready = !rst && !host_we;
  assign host_ready     = !rst && !pend;
  assign issue          = in_if.in_valid && in_if.in_ready;
  assign host_accept    = host_we && host_ready;

  // The result still on the fu output belongs to the pending instruction,
  // so a source matching its destination takes that value instead.
  assign byp_a = pend && (pend_rd == in_if.in_ra);
  assign byp_b = pend && (pend_rd == in_if.in_rb);

  assign host_rdata = regfile[host_raddr];
  assign busy_o     = pend;

  // Drive the fu only when an instruction issues; idle cycles present zeros.
  always_comb begin
    // NOTE: every output gets a default before the if, so no path leaves
    // it unassigned and no latch is inferred.
    fu_op_o = '0;
    fu_a_o  = '0;
    fu_b_o  = '0;
    if (issue) begin
      fu_op_o = in_if.in_op;
      fu_a_o  = byp_a ? fu_f_i : regfile[in_if.in_ra];
      fu_b_o  = byp_b ? fu_f_i : regfile[in_if.in_rb];
    end
  end

  // Writeback port is zeroed whenever no instruction is completing.
  always_comb begin
    wb_valid_o = pend;
    wb_addr_o  = '0;
    wb_data_o  = '0;
    if (pend) begin
      wb_addr_o = pend_rd;
      wb_data_o = fu_f_i;
    end
  end

  // Pipeline state, flags and register file updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register file is a small flop array that must read back
      // as zero after reset, so every entry is cleared here; this would not
      // map onto a RAM macro, which is acceptable at this depth.
      for (int i = 0; i < DEPTH; i++) regfile[i] <= '0;
      pend    <= 1'b0;
      pend_rd <= '0;
      flags_o <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so the regfile reads
      // above see pre-edge values regardless of statement order.
      if (pend) begin
        regfile[pend_rd] <= fu_f_i;
        flags_o          <= {fu_n_i, fu_z_i, fu_c_i, fu_v_i};
      end
      if (host_accept) regfile[host_waddr] <= host_wdata;
      pend <= issue;
      if (issue) pend_rd <= in_if.in_rd;
    end
  end

endmodule

// File: tb/tb_fu_issue.sv
// Bench for fu_issue: a registered adder stands in for the fu, a per-cycle
// vector table covers host load, issue, bypass, flags and host/pend
// interplay, and a hand sequence covers reset during an in-flight op.
module tb_fu_issue;

  localparam int OPSIZE = 5;
  localparam int DSIZE  = 16;
  localparam int AW     = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              host_we;
  logic              host_ready;
  logic [AW-1:0]     host_waddr;
  logic [DSIZE-1:0]  host_wdata;
  logic [AW-1:0]     host_raddr;
  logic [DSIZE-1:0]  host_rdata;
  logic [OPSIZE-1:0] fu_op_o;
  logic [DSIZE-1:0]  fu_a_o, fu_b_o;
  logic [DSIZE-1:0]  fu_f_i;
  logic              fu_n_i, fu_c_i, fu_v_i, fu_z_i;
  logic              wb_valid_o;
  logic [AW-1:0]     wb_addr_o;
  logic [DSIZE-1:0]  wb_data_o;
  logic [3:0]        flags_o;
  logic              busy_o;

  int checks = 0;
  int errors = 0;

  fu_issue_if #(.OPSIZE(OPSIZE), .AW(AW)) in_if ();

  fu_issue #(.OPSIZE(OPSIZE), .DSIZE(DSIZE), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_if      (in_if.slave),
    .host_we    (host_we),
    .host_ready (host_ready),
    .host_waddr (host_waddr),
    .host_wdata (host_wdata),
    .host_raddr (host_raddr),
    .host_rdata (host_rdata),
    .fu_op_o    (fu_op_o),
    .fu_a_o     (fu_a_o),
    .fu_b_o     (fu_b_o),
    .fu_f_i     (fu_f_i),
    .fu_n_i     (fu_n_i),
    .fu_c_i     (fu_c_i),
    .fu_v_i     (fu_v_i),
    .fu_z_i     (fu_z_i),
    .wb_valid_o (wb_valid_o),
    .wb_addr_o  (wb_addr_o),
    .wb_data_o  (wb_data_o),
    .flags_o    (flags_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  // Registered fu stand-in: F = a + b one cycle later, with adder flags.
  logic [DSIZE:0] stub_sum;
  assign stub_sum = {1'b0, fu_a_o} + {1'b0, fu_b_o};

  always_ff @(posedge clk) begin
    if (rst) begin
      fu_f_i <= '0;
      fu_n_i <= 1'b0;
      fu_c_i <= 1'b0;
      fu_v_i <= 1'b0;
      fu_z_i <= 1'b0;
    end else begin
      fu_f_i <= stub_sum[DSIZE-1:0];
      fu_n_i <= stub_sum[DSIZE-1];
      fu_c_i <= stub_sum[DSIZE];
      fu_z_i <= (stub_sum[DSIZE-1:0] == '0);
      fu_v_i <= (fu_a_o[DSIZE-1] == fu_b_o[DSIZE-1]) &&
                (stub_sum[DSIZE-1] != fu_a_o[DSIZE-1]);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One row per clock cycle: inputs driven in that cycle and the
  // combinational outputs expected during it.
  typedef struct packed {
    logic             rst;
    logic             iv;
    logic [AW-1:0]    rd, ra, rb;
    logic             hwe;
    logic [AW-1:0]    hwa;
    logic [DSIZE-1:0] hwd;
    logic [AW-1:0]    hra;
    logic             e_inr, e_hr;
    logic [DSIZE-1:0] e_a, e_b;
    logic             e_wv;
    logic [AW-1:0]    e_wa;
    logic [DSIZE-1:0] e_wd;
    logic [3:0]       e_fl;
    logic             e_busy;
    logic [DSIZE-1:0] e_hrd;
  } vec_t;

  function automatic vec_t mk(int r, int iv, int rd, int ra, int rb,
                              int hwe, int hwa, int hwd, int hra,
                              int e_inr, int e_hr, int e_a, int e_b,
                              int e_wv, int e_wa, int e_wd, int e_fl,
                              int e_busy, int e_hrd);
    vec_t v;
    v.rst = 1'(r);     v.iv = 1'(iv);
    v.rd = AW'(rd);    v.ra = AW'(ra);     v.rb = AW'(rb);
    v.hwe = 1'(hwe);   v.hwa = AW'(hwa);   v.hwd = DSIZE'(hwd);
    v.hra = AW'(hra);
    v.e_inr = 1'(e_inr); v.e_hr = 1'(e_hr);
    v.e_a = DSIZE'(e_a); v.e_b = DSIZE'(e_b);
    v.e_wv = 1'(e_wv);   v.e_wa = AW'(e_wa); v.e_wd = DSIZE'(e_wd);
    v.e_fl = 4'(e_fl);   v.e_busy = 1'(e_busy); v.e_hrd = DSIZE'(e_hrd);
    return v;
  endfunction

  task automatic drive(input logic r, input logic iv, input logic [OPSIZE-1:0] op,
                       input logic [AW-1:0] rd, input logic [AW-1:0] ra,
                       input logic [AW-1:0] rb, input logic hwe,
                       input logic [AW-1:0] hwa, input logic [DSIZE-1:0] hwd,
                       input logic [AW-1:0] hra);
    rst            = r;
    in_if.in_valid = iv;
    in_if.in_op    = op;
    in_if.in_rd    = rd;
    in_if.in_ra    = ra;
    in_if.in_rb    = rb;
    host_we        = hwe;
    host_waddr     = hwa;
    host_wdata     = hwd;
    host_raddr     = hra;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam int NV = 20;
  vec_t vecs [NV];

  initial begin
    //            rst iv rd ra rb hwe hwa hwd     hra  inr hr a       b       wv wa wd      fl       busy hrd
    vecs[0]  = mk(1,  0, 0, 0, 0, 0,  0,  0,      0,   0,  0, 0,      0,      0, 0, 0,      0,       0,   0);
    vecs[1]  = mk(0,  0, 0, 0, 0, 1,  1,  'h0005, 1,   0,  1, 0,      0,      0, 0, 0,      0,       0,   0);
    vecs[2]  = mk(0,  0, 0, 0, 0, 1,  2,  'h0003, 1,   0,  1, 0,      0,      0, 0, 0,      0,       0,   'h0005);
    vecs[3]  = mk(0,  0, 0, 0, 0, 0,  0,  0,      2,   1,  1, 0,      0,      0, 0, 0,      0,       0,   'h0003);
    // r3 = r1 + r2
    vecs[4]  = mk(0,  1, 3, 1, 2, 0,  0,  0,      3,   1,  1, 'h0005, 'h0003, 0, 0, 0,      0,       0,   0);
    // r4 = r3 + r3 issued while r3 is still on the fu output
    vecs[5]  = mk(0,  1, 4, 3, 3, 0,  0,  0,      3,   1,  0, 'h0008, 'h0008, 1, 3, 'h0008, 0,       1,   0);
    vecs[6]  = mk(0,  0, 0, 0, 0, 0,  0,  0,      3,   1,  0, 0,      0,      1, 4, 'h0010, 0,       1,   'h0008);
    vecs[7]  = mk(0,  0, 0, 0, 0, 1,  5,  'h0001, 4,   0,  1, 0,      0,      0, 0, 0,      0,       0,   'h0010);
    vecs[8]  = mk(0,  0, 0, 0, 0, 1,  6,  'hFFFF, 5,   0,  1, 0,      0,      0, 0, 0,      0,       0,   'h0001);
    // r7 = 1 + 0xFFFF -> 0 with Z and C set
    vecs[9]  = mk(0,  1, 7, 5, 6, 0,  0,  0,      6,   1,  1, 'h0001, 'hFFFF, 0, 0, 0,      0,       0,   'hFFFF);
    vecs[10] = mk(0,  0, 0, 0, 0, 0,  0,  0,      7,   1,  0, 0,      0,      1, 7, 0,      0,       1,   0);
    // flags held through idle cycles where the stub reports Z=1
    vecs[11] = mk(0,  0, 0, 0, 0, 0,  0,  0,      7,   1,  1, 0,      0,      0, 0, 0,      'b0110,  0,   0);
    vecs[12] = mk(0,  0, 0, 0, 0, 0,  0,  0,      7,   1,  1, 0,      0,      0, 0, 0,      'b0110,  0,   0);
    vecs[13] = mk(0,  0, 0, 0, 0, 0,  0,  0,      7,   1,  1, 0,      0,      0, 0, 0,      'b0110,  0,   0);
    // r1 = r1 + r1, then a host write and an instruction collide with pend
    vecs[14] = mk(0,  1, 1, 1, 1, 0,  0,  0,      1,   1,  1, 'h0005, 'h0005, 0, 0, 0,      'b0110,  0,   'h0005);
    vecs[15] = mk(0,  1, 0, 2, 1, 1,  2,  'h1234, 1,   0,  0, 0,      0,      1, 1, 'h000A, 'b0110,  1,   'h0005);
    vecs[16] = mk(0,  1, 0, 2, 1, 1,  2,  'h1234, 2,   0,  1, 0,      0,      0, 0, 0,      0,       0,   'h0003);
    vecs[17] = mk(0,  1, 0, 2, 1, 0,  0,  0,      2,   1,  1, 'h1234, 'h000A, 0, 0, 0,      0,       0,   'h1234);
    vecs[18] = mk(0,  0, 0, 0, 0, 0,  0,  0,      0,   1,  0, 0,      0,      1, 0, 'h123E, 0,       1,   0);
    vecs[19] = mk(0,  0, 0, 0, 0, 0,  0,  0,      0,   1,  1, 0,      0,      0, 0, 0,      0,       0,   'h123E);

    drive(1'b1, 1'b0, '0, '0, '0, '0, 1'b0, '0, '0, '0);
    repeat (2) next_cycle();

    for (int i = 0; i < NV; i++) begin
      logic [OPSIZE-1:0] op;
      op = OPSIZE'(i + 3);
      drive(vecs[i].rst, vecs[i].iv, op, vecs[i].rd, vecs[i].ra, vecs[i].rb,
            vecs[i].hwe, vecs[i].hwa, vecs[i].hwd, vecs[i].hra);
      #3;
      check($sformatf("v%0d in_ready", i),   32'(in_if.in_ready), 32'(vecs[i].e_inr));
      check($sformatf("v%0d host_ready", i), 32'(host_ready),     32'(vecs[i].e_hr));
      check($sformatf("v%0d fu_op", i),      32'(fu_op_o),
            (vecs[i].iv && vecs[i].e_inr) ? 32'(op) : 32'd0);
      check($sformatf("v%0d fu_a", i),       32'(fu_a_o),         32'(vecs[i].e_a));
      check($sformatf("v%0d fu_b", i),       32'(fu_b_o),         32'(vecs[i].e_b));
      check($sformatf("v%0d wb_valid", i),   32'(wb_valid_o),     32'(vecs[i].e_wv));
      check($sformatf("v%0d wb_addr", i),    32'(wb_addr_o),      32'(vecs[i].e_wa));
      check($sformatf("v%0d wb_data", i),    32'(wb_data_o),      32'(vecs[i].e_wd));
      check($sformatf("v%0d flags", i),      32'(flags_o),        32'(vecs[i].e_fl));
      check($sformatf("v%0d busy", i),       32'(busy_o),         32'(vecs[i].e_busy));
      check($sformatf("v%0d host_rdata", i), 32'(host_rdata),     32'(vecs[i].e_hrd));
      next_cycle();
    end

    // Set nonzero flags: r7 = 0xFFFF + 0xFFFF = 0xFFFE, N and C set.
    drive(1'b0, 1'b1, 5'h02, 3'd7, 3'd6, 3'd6, 1'b0, '0, '0, 3'd7);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, '0, '0, 3'd7);
    #3;
    check("seq wb_data FFFE", 32'(wb_data_o), 32'h0000_FFFE);
    next_cycle();
    #3;
    check("seq flags 1010", 32'(flags_o), 32'b1010);
    check("seq r7 FFFE", 32'(host_rdata), 32'h0000_FFFE);

    // In-flight r5 = r2 + r2, reset asserted in its writeback cycle.
    next_cycle();
    drive(1'b0, 1'b1, 5'h04, 3'd5, 3'd2, 3'd2, 1'b0, '0, '0, 3'd5);
    #3;
    check("seq rst issue fu_a", 32'(fu_a_o), 32'h0000_1234);
    next_cycle();
    drive(1'b1, 1'b0, '0, '0, '0, '0, 1'b0, '0, '0, 3'd5);
    #3;
    check("seq rst in_ready", 32'(in_if.in_ready), 32'd0);
    check("seq rst host_ready", 32'(host_ready), 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, '0, '0, 3'd0);
    #3;
    check("seq post-rst busy", 32'(busy_o), 32'd0);
    check("seq post-rst flags", 32'(flags_o), 32'd0);
    check("seq post-rst wb_valid", 32'(wb_valid_o), 32'd0);
    for (int r = 0; r < (1 << AW); r++) begin
      host_raddr = AW'(r);
      #1;
      check($sformatf("seq post-rst r%0d", r), 32'(host_rdata), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
